// File: rtl/spi_disp_tx_fifo.sv
// spi_disp_tx_fifo: FIFO-fed SPI display transmitter (CS/SCL/SDA/DC), MSB-first unless SPI_DISP_TX_LSB_FIRST_EN is defined
module spi_disp_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            in_dc,
    output logic                            in_ready,
    output logic                            cs,
    output logic                            scl,
    output logic                            sda,
    output logic                            dc,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    function automatic logic first_bit(input logic [DATA_W-1:0] x);
`ifdef SPI_DISP_TX_LSB_FIRST_EN
        return x[0];
`else
        return x[DATA_W-1];
`endif
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] x);
`ifdef SPI_DISP_TX_LSB_FIRST_EN
        return x >> 1;
`else
        return x << 1;
`endif
    endfunction

    logic [DATA_W:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [LW-1:0]      level;
    state_t             state, n_state;
    logic [CW-1:0]      cnt, n_cnt;
    logic [BW-1:0]      bitn, n_bit;
    logic [DATA_W-1:0]  sh, n_sh;
    logic               half, n_half, cont, n_cont;
    logic               cs_q, n_cs, scl_q, n_scl, sda_q, n_sda, dc_q, n_dc;
    logic               push, pop, tick, last, more;
    logic [DATA_W-1:0]  head_data;
    logic               head_dc;

    assign in_ready   = level != LW'(FIFO_DEPTH);
    assign push       = in_valid && in_ready;
    assign head_data  = mem[rd_ptr][DATA_W-1:0];
    assign head_dc    = mem[rd_ptr][DATA_W];
    assign tick       = cnt == CW'(CLK_DIV - 1);
    assign last       = bitn == BW'(DATA_W - 1);
    // a burst continues only into a word of the same DC type
    assign more       = level != '0 && head_dc == dc_q;
    assign cs         = cs_q;
    assign scl        = scl_q;
    assign sda        = sda_q;
    assign dc         = dc_q;
    assign busy       = state != IDLE || level != '0;
    assign fifo_level = level;

    always_comb begin
        n_state = state;
        n_cnt   = tick ? '0 : cnt + 1'b1;
        n_half  = half;
        n_bit   = bitn;
        n_cont  = cont;
        n_sh    = sh;
        n_cs    = cs_q;
        n_scl   = scl_q;
        n_sda   = sda_q;
        n_dc    = dc_q;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                n_cnt = '0;
                if (level != '0) begin
                    pop     = 1'b1;
                    n_sh    = head_data;
                    n_dc    = head_dc;
                    n_cs    = 1'b0;
                    n_sda   = first_bit(head_data);
                    n_state = SETUP;
                end
            end
            SETUP: if (tick) begin
                n_state = SHIFT;
                n_half  = 1'b0;
                n_bit   = '0;
                n_scl   = ~CPOL;
            end
            SHIFT: if (tick && !half) begin
                // trailing edge; the next burst word is fetched here so CPHA=0 can present its first bit early
                n_half = 1'b1;
                n_scl  = CPOL;
                if (!last) begin
                    n_sh  = CPHA ? sh : advance(sh);
                    n_sda = CPHA ? sda_q : first_bit(advance(sh));
                end else if (more) begin
                    pop    = 1'b1;
                    n_cont = 1'b1;
                    n_sh   = head_data;
                    n_sda  = CPHA ? sda_q : first_bit(head_data);
                end
            end else if (tick) begin
                n_half = 1'b0;
                if (!last || cont) begin
                    n_scl  = ~CPOL;
                    n_bit  = last ? '0 : bitn + 1'b1;
                    n_cont = 1'b0;
                    n_sh   = CPHA && !last ? advance(sh) : sh;
                    n_sda  = CPHA ? first_bit(last ? sh : advance(sh)) : sda_q;
                end else begin
                    n_state = HOLD;
                end
            end
            HOLD: if (tick) begin
                n_cs    = 1'b1;
                n_sda   = 1'b0;
                n_state = GAP;
            end
            GAP: if (tick) n_state = IDLE;
            default: n_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            half   <= 1'b0;
            bitn   <= '0;
            cont   <= 1'b0;
            sh     <= '0;
            cs_q   <= 1'b1;
            scl_q  <= CPOL;
            sda_q  <= 1'b0;
            dc_q   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            state  <= n_state;
            cnt    <= n_cnt;
            half   <= n_half;
            bitn   <= n_bit;
            cont   <= n_cont;
            sh     <= n_sh;
            cs_q   <= n_cs;
            scl_q  <= n_scl;
            sda_q  <= n_sda;
            dc_q   <= n_dc;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            level  <= level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_dc, in_data};
    end
endmodule
